// File: rtl/mem_arbiter.sv
// Two-client round-robin arbiter in front of mem_ctrl. Read responses are steered
// back to their requester through an in-order FIFO of client ids.
module mem_arbiter #(
  parameter int addr_width      = 20,
  parameter int line_width      = 64,
  parameter int max_outstanding = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [addr_width-1:0] c0_addr_i,
  input  logic                  c0_r_valid_i,
  input  logic                  c0_w_valid_i,
  input  logic [line_width-1:0] c0_write_i,
  output logic                  c0_ready_o,
  output logic                  c0_r_valid_o,
  output logic [line_width-1:0] c0_read_o,
  input  logic [addr_width-1:0] c1_addr_i,
  input  logic                  c1_r_valid_i,
  input  logic                  c1_w_valid_i,
  input  logic [line_width-1:0] c1_write_i,
  output logic                  c1_ready_o,
  output logic                  c1_r_valid_o,
  output logic [line_width-1:0] c1_read_o,
  input  logic                  mem_enabled_i,
  input  logic                  mem_ready_i,
  output logic [addr_width-1:0] mem_addr_o,
  output logic                  mem_r_valid_o,
  output logic                  mem_w_valid_o,
  output logic [line_width-1:0] mem_write_o,
  input  logic                  mem_r_valid_i,
  input  logic [line_width-1:0] mem_read_i,
  output logic                  err_o
);

  localparam int ptr_width = $clog2(max_outstanding);
  localparam logic [ptr_width-1:0] ptr_one  = 1;
  localparam logic [ptr_width:0]   cnt_one  = 1;
  localparam logic [ptr_width:0]   cnt_full = (ptr_width + 1)'(max_outstanding);

  logic                 prio;
  logic [ptr_width:0]   count;
  logic [ptr_width-1:0] wr_ptr;
  logic [ptr_width-1:0] rd_ptr;
  logic                 tag_mem [max_outstanding];

  logic fifo_full;
  logic fifo_empty;
  logic elig0;
  logic elig1;
  logic grant_valid;
  logic grant_id;
  logic grant_rd;
  logic accept;
  logic push;
  logic pop;
  logic head_id;

  assign fifo_full  = (count == cnt_full);
  assign fifo_empty = (count == '0);

  // A request carrying both read and write is a read, so it is blocked by a full FIFO.
  assign elig0 = (c0_r_valid_i | c0_w_valid_i) & ~(c0_r_valid_i & fifo_full);
  assign elig1 = (c1_r_valid_i | c1_w_valid_i) & ~(c1_r_valid_i & fifo_full);

  assign grant_valid = elig0 | elig1;
  assign grant_id    = (elig0 & elig1) ? prio : elig1;
  assign grant_rd    = grant_id ? c1_r_valid_i : c0_r_valid_i;

  assign mem_addr_o    = grant_id ? c1_addr_i : c0_addr_i;
  assign mem_write_o   = grant_id ? c1_write_i : c0_write_i;
  assign mem_r_valid_o = grant_valid & mem_enabled_i & grant_rd;
  assign mem_w_valid_o = grant_valid & mem_enabled_i & ~grant_rd;

  assign accept     = grant_valid & mem_enabled_i & mem_ready_i;
  assign c0_ready_o = accept & ~grant_id;
  assign c1_ready_o = accept & grant_id;

  assign push    = accept & grant_rd;
  assign pop     = mem_r_valid_i & ~fifo_empty;
  assign head_id = tag_mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (push) tag_mem[wr_ptr] <= grant_id;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prio         <= 1'b0;
      count        <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      c0_r_valid_o <= 1'b0;
      c1_r_valid_o <= 1'b0;
      c0_read_o    <= '0;
      c1_read_o    <= '0;
      err_o        <= 1'b0;
    end else begin
      // The client that just lost (or did not compete) gets priority next time.
      if (accept) prio <= ~grant_id;
      if (push) wr_ptr <= wr_ptr + ptr_one;
      if (pop) rd_ptr <= rd_ptr + ptr_one;
      if (push & ~pop) count <= count + cnt_one;
      else if (pop & ~push) count <= count - cnt_one;
      c0_r_valid_o <= pop & ~head_id;
      c1_r_valid_o <= pop & head_id;
      if (pop & ~head_id) c0_read_o <= mem_read_i;
      if (pop & head_id) c1_read_o <= mem_read_i;
      if (mem_r_valid_i & fifo_empty) err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter, checked every cycle against a
// queue-based reference model of grant, tag ordering and response routing.
module tb_mem_arbiter;

  localparam int aw = 20;
  localparam int lw = 64;
  localparam int max_out = 4;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic [aw-1:0] c0_addr_i, c1_addr_i, mem_addr_o;
  logic c0_r_valid_i, c0_w_valid_i, c1_r_valid_i, c1_w_valid_i;
  logic [lw-1:0] c0_write_i, c1_write_i, c0_read_o, c1_read_o, mem_write_o;
  logic c0_ready_o, c1_ready_o, c0_r_valid_o, c1_r_valid_o;
  logic mem_enabled_i, mem_ready_i, mem_r_valid_o, mem_w_valid_o, mem_r_valid_i, err_o;
  logic [lw-1:0] mem_read_i;

  logic [aw-1:0] st_addr [2];
  logic          st_rv   [2];
  logic          st_wv   [2];
  logic [lw-1:0] st_data [2];

  assign c0_addr_i    = st_addr[0];
  assign c1_addr_i    = st_addr[1];
  assign c0_r_valid_i = st_rv[0];
  assign c1_r_valid_i = st_rv[1];
  assign c0_w_valid_i = st_wv[0];
  assign c1_w_valid_i = st_wv[1];
  assign c0_write_i   = st_data[0];
  assign c1_write_i   = st_data[1];

  mem_arbiter #(.addr_width(aw), .line_width(lw), .max_outstanding(max_out)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .c0_addr_i(c0_addr_i), .c0_r_valid_i(c0_r_valid_i), .c0_w_valid_i(c0_w_valid_i),
    .c0_write_i(c0_write_i), .c0_ready_o(c0_ready_o), .c0_r_valid_o(c0_r_valid_o),
    .c0_read_o(c0_read_o),
    .c1_addr_i(c1_addr_i), .c1_r_valid_i(c1_r_valid_i), .c1_w_valid_i(c1_w_valid_i),
    .c1_write_i(c1_write_i), .c1_ready_o(c1_ready_o), .c1_r_valid_o(c1_r_valid_o),
    .c1_read_o(c1_read_o),
    .mem_enabled_i(mem_enabled_i), .mem_ready_i(mem_ready_i),
    .mem_addr_o(mem_addr_o), .mem_r_valid_o(mem_r_valid_o), .mem_w_valid_o(mem_w_valid_o),
    .mem_write_o(mem_write_o), .mem_r_valid_i(mem_r_valid_i), .mem_read_i(mem_read_i),
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit            m_prio;
  int            tag_q [$];
  logic          m_rvo [2];
  logic [lw-1:0] m_rdo [2];
  logic          m_err;
  bit            m_acc;
  int            m_gid;

  // Values seen in the last cycle, for directed checks
  logic [aw-1:0] seen_addr;
  logic [lw-1:0] seen_wdata;
  logic          seen_rv, seen_wv, seen_rdy0, seen_rdy1, seen_err;
  logic          seen_rvo [2];
  logic [lw-1:0] seen_rdo [2];

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic checkRegs();
    checkOutput("c0_r_valid", c0_r_valid_o, m_rvo[0]);
    checkOutput("c1_r_valid", c1_r_valid_o, m_rvo[1]);
    checkOutput("c0_read", c0_read_o, m_rdo[0]);
    checkOutput("c1_read", c1_read_o, m_rdo[1]);
    checkOutput("err", err_o, m_err);
  endtask

  task automatic clearReq();
    for (int i = 0; i < 2; i++) begin
      st_rv[i] = 1'b0;
      st_wv[i] = 1'b0;
      st_addr[i] = '0;
      st_data[i] = '0;
    end
  endtask

  task automatic setReq(input int c, input bit rd, input bit wr, input logic [aw-1:0] a,
                        input logic [lw-1:0] d);
    st_rv[c] = rd;
    st_wv[c] = wr;
    st_addr[c] = a;
    st_data[c] = d;
  endtask

  task automatic doReset();
    rst_i = 1'b1;
    m_prio = 1'b0;
    tag_q.delete();
    m_rvo = '{1'b0, 1'b0};
    m_rdo = '{64'd0, 64'd0};
    m_err = 1'b0;
    #2;
    checkRegs();
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  // One clock cycle: check combinational outputs, advance the model, check registered outputs.
  task automatic applyStimulus();
    bit elig [2];
    bit has_g;
    int gid;
    int h;
    #1;
    for (int i = 0; i < 2; i++)
      elig[i] = (st_rv[i] || st_wv[i]) && !(st_rv[i] && tag_q.size() >= max_out);
    has_g = elig[0] || elig[1];
    gid = (elig[0] && elig[1]) ? int'(m_prio) : (elig[1] ? 1 : 0);
    m_acc = has_g && mem_enabled_i && mem_ready_i;
    m_gid = gid;
    checkOutput("mem_addr", mem_addr_o, st_addr[gid]);
    checkOutput("mem_write", mem_write_o, st_data[gid]);
    checkOutput("mem_r_valid", mem_r_valid_o, has_g && mem_enabled_i && st_rv[gid]);
    checkOutput("mem_w_valid", mem_w_valid_o, has_g && mem_enabled_i && !st_rv[gid]);
    checkOutput("c0_ready", c0_ready_o, m_acc && gid == 0);
    checkOutput("c1_ready", c1_ready_o, m_acc && gid == 1);
    seen_addr = mem_addr_o;
    seen_wdata = mem_write_o;
    seen_rv = mem_r_valid_o;
    seen_wv = mem_w_valid_o;
    seen_rdy0 = c0_ready_o;
    seen_rdy1 = c1_ready_o;
    @(posedge clk_i);
    m_rvo = '{1'b0, 1'b0};
    if (mem_r_valid_i) begin
      if (tag_q.size() > 0) begin
        h = tag_q.pop_front();
        m_rvo[h] = 1'b1;
        m_rdo[h] = mem_read_i;
      end else begin
        m_err = 1'b1;
      end
    end
    if (m_acc) begin
      m_prio = (gid == 0);
      if (st_rv[gid]) tag_q.push_back(gid);
    end
    #1;
    checkRegs();
    seen_rvo = '{c0_r_valid_o, c1_r_valid_o};
    seen_rdo = '{c0_read_o, c1_read_o};
    seen_err = err_o;
  endtask

  task automatic drain(input int n);
    clearReq();
    for (int k = 0; k < n; k++) begin
      mem_r_valid_i = 1'b1;
      mem_read_i = {32'hCAFE0000, 32'(k)};
      applyStimulus();
    end
    mem_r_valid_i = 1'b0;
    applyStimulus();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [aw-1:0] t2_exp [4];
    logic [lw-1:0] t5_dat [3];
    int t5_who [3];
    bit pend [2];
    int kind;
    t2_exp = '{20'h10, 20'h20, 20'h10, 20'h20};
    t5_dat = '{64'hA, 64'hB, 64'hC};
    t5_who = '{0, 1, 0};

    clearReq();
    mem_enabled_i = 1'b0;
    mem_ready_i = 1'b0;
    mem_r_valid_i = 1'b0;
    mem_read_i = '0;
    #3;
    doReset();

    $display("[TB] disabled memory issues nothing");
    setReq(0, 1, 0, 20'h10, 64'd0);
    mem_ready_i = 1'b1;
    applyStimulus();
    checkOutput("t1_r_valid", seen_rv, 1'b0);
    checkOutput("t1_ready0", seen_rdy0, 1'b0);

    $display("[TB] round robin between two readers");
    mem_enabled_i = 1'b1;
    setReq(1, 1, 0, 20'h20, 64'd0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus();
      checkOutput("t2_addr", seen_addr, t2_exp[k]);
    end
    applyStimulus();
    checkOutput("t2_full_blocks", seen_rv, 1'b0);
    drain(4);

    $display("[TB] single write");
    setReq(0, 0, 1, 20'h5, 64'hDEADBEEF_00000001);
    applyStimulus();
    checkOutput("t3_w_valid", seen_wv, 1'b1);
    checkOutput("t3_addr", seen_addr, 20'h5);
    checkOutput("t3_data", seen_wdata, 64'hDEADBEEF_00000001);
    clearReq();
    mem_r_valid_i = 1'b1;
    applyStimulus();
    checkOutput("t3_no_tag", seen_err, 1'b1);
    mem_r_valid_i = 1'b0;
    doReset();

    $display("[TB] full tag FIFO blocks reads only");
    for (int k = 0; k < 4; k++) begin
      setReq(1, 1, 0, 20'(32'h30 + k), 64'd0);
      applyStimulus();
      checkOutput("t4_fill", seen_rdy1, 1'b1);
    end
    setReq(1, 1, 0, 20'h34, 64'd0);
    applyStimulus();
    checkOutput("t4_blocked", seen_rdy1, 1'b0);
    setReq(1, 0, 1, 20'h40, 64'h1234);
    applyStimulus();
    checkOutput("t4_write_ok", seen_rdy1, 1'b1);
    setReq(1, 1, 0, 20'h34, 64'd0);
    mem_r_valid_i = 1'b1;
    mem_read_i = 64'h77;
    applyStimulus();
    checkOutput("t4_pop_same_cycle", seen_rdy1, 1'b0);
    mem_r_valid_i = 1'b0;
    applyStimulus();
    checkOutput("t4_unblocked", seen_rdy1, 1'b1);
    drain(4);

    $display("[TB] in-order response routing");
    setReq(0, 1, 0, 20'h50, 64'd0);
    applyStimulus();
    clearReq();
    setReq(1, 1, 0, 20'h51, 64'd0);
    applyStimulus();
    clearReq();
    setReq(0, 1, 0, 20'h52, 64'd0);
    applyStimulus();
    clearReq();
    for (int k = 0; k < 3; k++) begin
      mem_r_valid_i = 1'b1;
      mem_read_i = t5_dat[k];
      applyStimulus();
      checkOutput("t5_valid", seen_rvo[t5_who[k]], 1'b1);
      checkOutput("t5_other", seen_rvo[1 - t5_who[k]], 1'b0);
      checkOutput("t5_data", seen_rdo[t5_who[k]], t5_dat[k]);
    end
    mem_r_valid_i = 1'b0;
    applyStimulus();
    checkOutput("t5_c0_hold", seen_rdo[0], 64'hC);
    checkOutput("t5_c1_hold", seen_rdo[1], 64'hB);

    $display("[TB] response with empty FIFO");
    mem_r_valid_i = 1'b1;
    mem_read_i = 64'h99;
    applyStimulus();
    checkOutput("t6_err", seen_err, 1'b1);
    checkOutput("t6_no_c0", seen_rvo[0], 1'b0);
    checkOutput("t6_no_c1", seen_rvo[1], 1'b0);
    mem_r_valid_i = 1'b0;
    applyStimulus();
    applyStimulus();
    checkOutput("t6_sticky", seen_err, 1'b1);
    doReset();
    checkOutput("t6_cleared", err_o, 1'b0);
    setReq(0, 1, 0, 20'h60, 64'd0);
    applyStimulus();
    clearReq();
    doReset();
    mem_r_valid_i = 1'b1;
    applyStimulus();
    checkOutput("t6_late_resp", seen_err, 1'b1);
    mem_r_valid_i = 1'b0;
    doReset();

    $display("[TB] random traffic");
    pend = '{1'b0, 1'b0};
    clearReq();
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && ($urandom % 3) != 0) begin
          kind = int'($urandom % 3);
          setReq(i, kind != 1, kind != 0, 20'($urandom), {$urandom, $urandom});
          pend[i] = 1'b1;
        end else if (!pend[i]) begin
          setReq(i, 0, 0, 20'($urandom), {$urandom, $urandom});
        end
      end
      mem_enabled_i = ($urandom % 8) != 0;
      mem_ready_i = ($urandom % 4) != 0;
      mem_r_valid_i = (tag_q.size() > 0) && ($urandom % 2 == 0);
      mem_read_i = {$urandom, $urandom};
      applyStimulus();
      if (m_acc) pend[m_gid] = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
